// File: rtl/btn_debounce.sv
// btn_debounce: conditions raw push-button inputs into clean signals.
// Each button is synchronised to CLK, debounced on a shared prescaler tick, and
// produces a debounced level, one-cycle press/release pulses and auto-repeat
// pulses while held.
//
// Ports:
//   CLK          system clock
//   RST          asynchronous active-high reset
//   BTN          raw button inputs (1 = pressed), asynchronous to CLK
//   BTN_LVL      debounced level
//   BTN_PRESS    one-cycle pulse on an accepted 0->1
//   BTN_RELEASE  one-cycle pulse on an accepted 1->0
//   BTN_REP      one-cycle auto-repeat pulse while held
//   TICK         prescaler tick, high one cycle every 2^DIV_W cycles
module btn_debounce #(
   parameter int unsigned N_BTN      = 4,
   parameter int unsigned DIV_W      = 17,
   parameter int unsigned STABLE     = 4,
   parameter int unsigned HOLD_TICKS = 64,
   parameter int unsigned REP_TICKS  = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_BTN-1:0] BTN,
   output logic [N_BTN-1:0] BTN_LVL,
   output logic [N_BTN-1:0] BTN_PRESS,
   output logic [N_BTN-1:0] BTN_RELEASE,
   output logic [N_BTN-1:0] BTN_REP,
   output logic             TICK
);

   localparam int unsigned SW   = $clog2(STABLE + 1);
   localparam int unsigned RMAX = (HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS;
   localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE - 1);
   localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] REP_LAST    = RW'(REP_TICKS - 1);

   typedef enum logic [1:0] {StIdle, StHold, StRepeat} rep_state_e;

   // Prescaler: TICK follows the all-ones count by one register stage.
   logic [DIV_W-1:0] div_q;
   logic             tick_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_q + DIV_W'(1);
         tick_q <= &div_q;
      end
   end

   assign TICK = tick_q;

   // Two-flop synchroniser; only s2_q feeds the debounce logic.
   logic [N_BTN-1:0] s1_q;
   logic [N_BTN-1:0] s2_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= BTN;
         s2_q <= s1_q;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      logic [SW-1:0] stab_q;
      logic          lvl_q;
      logic          press_q;
      logic          release_q;
      logic          accept;
      logic          acc_press;
      logic          acc_release;
      rep_state_e    state_q, state_d;
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          rep_q, rep_d;

      // Accept on the STABLE-th consecutive differing tick sample.
      assign accept      = tick_q && (s2_q[i] != lvl_q) && (stab_q == STABLE_LAST);
      assign acc_press   = accept && s2_q[i];
      assign acc_release = accept && !s2_q[i];

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            stab_q    <= '0;
            lvl_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= acc_press;
            release_q <= acc_release;
            if (tick_q) begin
               // Agreeing sample restarts the run; acceptance also clears it.
               if ((s2_q[i] == lvl_q) || accept) begin
                  stab_q <= '0;
               end else begin
                  stab_q <= stab_q + SW'(1);
               end
               if (accept) begin
                  lvl_q <= s2_q[i];
               end
            end
         end
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            state_q <= StIdle;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rep_q   <= rep_d;
         end
      end

      // Release is tested before the tick count, so it wins over a due repeat.
      always_comb begin
         state_d = state_q;
         rcnt_d  = rcnt_q;
         rep_d   = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (acc_press) begin
                  state_d = StHold;
                  rcnt_d  = '0;
               end
            end
            StHold: begin
               if (acc_release) begin
                  state_d = StIdle;
                  rcnt_d  = '0;
               end else if (tick_q) begin
                  if (rcnt_q == HOLD_LAST) begin
                     rep_d   = 1'b1;
                     state_d = StRepeat;
                     rcnt_d  = '0;
                  end else begin
                     rcnt_d = rcnt_q + RW'(1);
                  end
               end
            end
            StRepeat: begin
               if (acc_release) begin
                  state_d = StIdle;
                  rcnt_d  = '0;
               end else if (tick_q) begin
                  if (rcnt_q == REP_LAST) begin
                     rep_d  = 1'b1;
                     rcnt_d = '0;
                  end else begin
                     rcnt_d = rcnt_q + RW'(1);
                  end
               end
            end
            default: begin
               state_d = StIdle;
               rcnt_d  = '0;
            end
         endcase
      end

      assign BTN_LVL[i]     = lvl_q;
      assign BTN_PRESS[i]   = press_q;
      assign BTN_RELEASE[i] = release_q;
      assign BTN_REP[i]     = rep_q;
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with a small, fast configuration.
// The driver applies stimulus and runs a tick-level reference model that pushes
// expected events (with the cycle they must appear in) onto a queue; a monitor
// on the falling edge pops and compares against what the DUT shows.
module tb_btn_debounce;

   localparam int N_BTN      = 4;
   localparam int DIV_W      = 2;
   localparam int STABLE     = 3;
   localparam int HOLD_TICKS = 4;
   localparam int REP_TICKS  = 2;
   localparam int PERIOD     = 1 << DIV_W;

   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_REP   = 2;

   logic             CLK;
   logic             RST;
   logic [N_BTN-1:0] BTN;
   logic [N_BTN-1:0] BTN_LVL;
   logic [N_BTN-1:0] BTN_PRESS;
   logic [N_BTN-1:0] BTN_RELEASE;
   logic [N_BTN-1:0] BTN_REP;
   logic             TICK;

   btn_debounce #(
      .N_BTN     (N_BTN),
      .DIV_W     (DIV_W),
      .STABLE    (STABLE),
      .HOLD_TICKS(HOLD_TICKS),
      .REP_TICKS (REP_TICKS)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BTN        (BTN),
      .BTN_LVL    (BTN_LVL),
      .BTN_PRESS  (BTN_PRESS),
      .BTN_RELEASE(BTN_RELEASE),
      .BTN_REP    (BTN_REP),
      .TICK       (TICK)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks;
   int errors;

   // Cycle n = state after the n-th rising edge since reset release.
   int cyc;
   always @(posedge CLK or posedge RST) begin
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   typedef struct {
      int at;
      int btn;
      int kind;
   } ev_t;

   ev_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model (tick level) ----------------
   bit               hist[N_BTN][$];   // tick samples since the last accepted change
   logic [N_BTN-1:0] m_lvl;
   int               press_tick[N_BTN];

   task automatic push_ev(input int at, input int b, input int kind);
      ev_t e;
      e.at   = at;
      e.btn  = b;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   task automatic model_clear();
      for (int i = 0; i < N_BTN; i++) begin
         hist[i].delete();
         press_tick[i] = 0;
      end
      m_lvl = '0;
   endtask

   // Tick t sees sample s; its effect is visible in cycle 'at'.
   task automatic model_tick(input int i, input int t, input bit s, input int at);
      bit all_diff;
      int d;
      hist[i].push_back(s);
      if (hist[i].size() > STABLE) void'(hist[i].pop_front());
      all_diff = (hist[i].size() == STABLE);
      for (int k = 0; k < hist[i].size(); k++) begin
         if (hist[i][k] == m_lvl[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
         m_lvl[i] = s;
         hist[i].delete();
         if (s) begin
            push_ev(at, i, K_PRESS);
            press_tick[i] = t;
         end else begin
            push_ev(at, i, K_REL);
         end
      end else if (m_lvl[i]) begin
         d = t - press_tick[i];
         if (d == HOLD_TICKS || (d > HOLD_TICKS && (d - HOLD_TICKS) % REP_TICKS == 0))
            push_ev(at, i, K_REP);
      end
   endtask

   // Value driven in cycle c is what the debouncer samples in cycle c+2; ticks
   // fall in cycles that are positive multiples of PERIOD; results show in c+3.
   task automatic model_cycle(input int c, input logic [N_BTN-1:0] b);
      int n;
      n = c + 2;
      if (n >= PERIOD && n % PERIOD == 0) begin
         for (int i = 0; i < N_BTN; i++) model_tick(i, n / PERIOD, b[i], n + 1);
      end
   endtask

   // ---------------- monitor ----------------
   ev_t              ev;
   logic [N_BTN-1:0] exp_lvl;
   logic [N_BTN-1:0] exp_p, exp_r, exp_rep;
   logic             exp_tick;

   always @(negedge CLK) begin
      if (RST) begin
         exp_q.delete();
         exp_lvl = '0;
         check("reset_outputs", {BTN_LVL, BTN_PRESS, BTN_RELEASE, BTN_REP, TICK}, 32'd0);
      end else begin
         exp_p   = '0;
         exp_r   = '0;
         exp_rep = '0;
         while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            ev = exp_q.pop_front();
            case (ev.kind)
               K_PRESS: begin exp_p[ev.btn] = 1'b1; exp_lvl[ev.btn] = 1'b1; end
               K_REL:   begin exp_r[ev.btn] = 1'b1; exp_lvl[ev.btn] = 1'b0; end
               default: exp_rep[ev.btn] = 1'b1;
            endcase
         end
         exp_tick = (cyc != 0) && (cyc % PERIOD == 0);
         check("pulses_press_release_rep", {BTN_PRESS, BTN_RELEASE, BTN_REP},
               {exp_p, exp_r, exp_rep});
         check("level", BTN_LVL, exp_lvl);
         check("tick", TICK, exp_tick);
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic [N_BTN-1:0] b);
      BTN = b;
      model_cycle(cyc, b);
      @(posedge CLK);
      #2;
   endtask

   // Assert RST between edges, confirm the asynchronous clear, release later.
   task automatic do_reset(input logic [N_BTN-1:0] b);
      BTN = b;
      RST = 1'b1;
      #1;
      check("async_clear", {BTN_LVL, BTN_PRESS, BTN_RELEASE, BTN_REP, TICK}, 32'd0);
      model_clear();
      repeat (3) begin
         @(posedge CLK);
         #2;
      end
      RST = 1'b0;
   endtask

   int               held;
   bit               done;
   int               r;
   logic [N_BTN-1:0] cur;

   initial begin
      checks = 0;
      errors = 0;
      BTN    = '0;
      RST    = 1'b0;
      model_clear();
      #1;

      // Buttons held through reset must still pass full debounce.
      do_reset(4'b1111);
      repeat (40) step(4'b1111);
      repeat (30) step(4'b0000);

      // Bounce on BTN[0]: 5-cycle half period never gives 3 agreeing ticks.
      for (int n = 0; n < 40; n++) step((n / 5) % 2 == 0 ? 4'b0001 : 4'b0000);
      repeat (30) step(4'b0000);

      // Hold BTN[1] at least 80 cycles, then drop it so the accepting tick
      // lands on a tick where a repeat would be due.
      held = 0;
      done = 1'b0;
      while (!done && held < 400) begin
         r = (cyc + 11) / PERIOD;
         if (held >= 80 && (cyc + 11) % PERIOD == 0 && m_lvl[1] &&
             r - press_tick[1] >= HOLD_TICKS &&
             (r - press_tick[1] - HOLD_TICKS) % REP_TICKS == 0) begin
            done = 1'b1;
         end else begin
            step(4'b0010);
            held++;
         end
      end
      check("release_slot_found", {31'd0, done}, 32'd1);
      repeat (40) step(4'b0000);

      // Simultaneous press on BTN[3:2]; release only BTN[3].
      repeat (60) step(4'b1100);
      repeat (40) step(4'b0100);
      repeat (30) step(4'b0000);

      // Reset while BTN[0] is repeating; it stays held and presses afresh.
      repeat (44) step(4'b0001);
      do_reset(4'b0001);
      repeat (40) step(4'b0001);
      repeat (30) step(4'b0000);

      // Random slow toggling on all buttons.
      cur = '0;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < N_BTN; i++) begin
            if ($urandom_range(0, 23) == 0) cur[i] = ~cur[i];
         end
         step(cur);
      end
      repeat (40) step(4'b0000);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
